// File: rtl/output_arbiter.sv
// output_arbiter: round-robin arbiter sharing one router output port between
// N_PORTS first-word-fall-through ingress FIFOs. A grant is held for a burst of
// up to MAX_BURST words, each presented on data_out under a req/ack handshake.
// Optional feature macro: YAS_ARB_WATCHDOG_EN (drop a word after WD_TIMEOUT
// cycles without ack and pulse wd_err).
module output_arbiter #(
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned DW         = 8,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned WD_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_PORTS-1:0]         fifo_empty,
  input  logic [N_PORTS*DW-1:0]      fifo_rdata,
  output logic [N_PORTS-1:0]         fifo_pop,
  output logic [DW-1:0]              data_out,
  output logic                       data_out_req,
  input  logic                       data_out_ack,
  output logic                       grant_vld,
  output logic [$clog2(N_PORTS)-1:0] grant_id,
  output logic                       wd_err
);

  localparam int unsigned GW = $clog2(N_PORTS);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  // Reject parameter sets the datapath widths cannot represent.
  if (N_PORTS < 2 || MAX_BURST < 1 || WD_TIMEOUT < 2) begin : g_bad_params
    $error("output_arbiter: illegal parameter set");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     data_d;
  logic              req_d;
  logic              gvld_d;
  logic [GW-1:0]     gid_d;
  logic [GW-1:0]     last_q, last_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [N_PORTS-1:0] pop_d;

  logic              win_vld;
  logic [GW-1:0]     win_id;
  logic [GW-1:0]     cand;

  // Round-robin pick: first non-empty port after last_grant, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int k = int'(N_PORTS); k >= 1; k--) begin
      cand = GW'((32'(last_q) + 32'(k)) % N_PORTS);
      if (!fifo_empty[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

`ifdef YAS_ARB_WATCHDOG_EN
  localparam int unsigned WW = $clog2(WD_TIMEOUT);
  logic [WW-1:0] wd_q, wd_d;
  logic          wd_err_d;
`endif

  // Next-state, pop and output-register inputs.
  always_comb begin
    state_d = state_q;
    data_d  = data_out;
    req_d   = data_out_req;
    gid_d   = grant_id;
    last_d  = last_q;
    burst_d = burst_q;
    pop_d   = '0;
`ifdef YAS_ARB_WATCHDOG_EN
    wd_d     = wd_q;
    wd_err_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          pop_d[win_id] = 1'b1;
          data_d        = fifo_rdata[32'(win_id)*DW +: DW];
          gid_d         = win_id;
          burst_d       = BW'(1);
          req_d         = 1'b1;
          state_d       = SEND;
        end
      end
      SEND: begin
        if (data_out_ack) begin
`ifdef YAS_ARB_WATCHDOG_EN
          wd_d = '0;
`endif
          if (burst_q < BW'(MAX_BURST) && !fifo_empty[grant_id]) begin
            pop_d[grant_id] = 1'b1;
            data_d          = fifo_rdata[32'(grant_id)*DW +: DW];
            burst_d         = burst_q + BW'(1);
          end else begin
            req_d   = 1'b0;
            last_d  = grant_id;
            state_d = IDLE;
          end
        end else begin
`ifdef YAS_ARB_WATCHDOG_EN
          // Stalled word: give up on it once the watchdog expires.
          if (wd_q == WW'(WD_TIMEOUT - 1)) begin
            wd_d     = '0;
            wd_err_d = 1'b1;
            req_d    = 1'b0;
            last_d   = grant_id;
            state_d  = IDLE;
          end else begin
            wd_d = wd_q + WW'(1);
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    gvld_d = (state_d == SEND);
  end

  // A pop during reset would discard a word nobody captures.
  assign fifo_pop = rst_n ? pop_d : '0;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      data_out     <= '0;
      data_out_req <= 1'b0;
      grant_vld    <= 1'b0;
      grant_id     <= '0;
      last_q       <= GW'(N_PORTS - 1);
      burst_q      <= '0;
    end else begin
      state_q      <= state_d;
      data_out     <= data_d;
      data_out_req <= req_d;
      grant_vld    <= gvld_d;
      grant_id     <= gid_d;
      last_q       <= last_d;
      burst_q      <= burst_d;
    end
  end

`ifdef YAS_ARB_WATCHDOG_EN
  // Watchdog counter and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q   <= '0;
      wd_err <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      wd_err <= wd_err_d;
    end
  end
`else
  assign wd_err = 1'b0;
`endif

endmodule

// File: tb/tb_output_arbiter.sv
// Testbench for output_arbiter: queue-backed FIFOs, randomized traffic and
// ack, compared cycle by cycle against a transaction-level reference model.
module tb_output_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int WD = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    fifo_empty;
  logic [N*DW-1:0] fifo_rdata;
  logic [N-1:0]    fifo_pop;
  logic [DW-1:0]   data_out;
  logic            data_out_req;
  logic            data_out_ack;
  logic            grant_vld;
  logic [1:0]      grant_id;
  logic            wd_err;

  output_arbiter #(
    .N_PORTS   (N),
    .DW        (DW),
    .MAX_BURST (MB),
    .WD_TIMEOUT(WD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rdata   (fifo_rdata),
    .fifo_pop     (fifo_pop),
    .data_out     (data_out),
    .data_out_req (data_out_req),
    .data_out_ack (data_out_ack),
    .grant_vld    (grant_vld),
    .grant_id     (grant_id),
    .wd_err       (wd_err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q [N][$];
  int checks = 0;
  int errors = 0;

  // Reference model: who holds the port, what word is on the wire.
  bit            m_busy;
  bit            m_req;
  logic [DW-1:0] m_data;
  int            m_gid;
  int            m_last;
  int            m_words;
  int            m_stall;
  bit            m_wderr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic update_fifos();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (q[i].size() == 0);
      fifo_rdata[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : '0;
    end
  endtask

  task automatic push(input int p, input int n);
    for (int j = 0; j < n; j++) q[p].push_back(DW'($urandom));
    update_fifos();
  endtask

  task automatic model_reset();
    m_busy = 0; m_req = 0; m_data = '0; m_gid = 0;
    m_last = N - 1; m_words = 0; m_stall = 0; m_wderr = 0;
  endtask

  task automatic check_outputs();
    check("req",   32'(data_out_req), 32'(m_req));
    check("data",  32'(data_out),     32'(m_data));
    check("gvld",  32'(grant_vld),    32'(m_busy));
    check("gid",   32'(grant_id),     32'(m_gid));
    check("wderr", 32'(wd_err),       32'(m_wderr));
  endtask

  // One clock: check registered outputs, drive ack, predict pop and next state.
  task automatic step(input logic ack_v);
    int           pop_idx;
    bit           found;
    logic [N-1:0] ep;
    @(negedge clk);
    check_outputs();
    data_out_ack = ack_v;
    #1;
    ep = '0;
    pop_idx = -1;
    found = 0;
    m_wderr = 0;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        if (!found && q[(m_last + k) % N].size() > 0) begin
          found = 1;
          pop_idx = (m_last + k) % N;
        end
      end
      if (found) begin
        m_busy = 1; m_req = 1; m_gid = pop_idx;
        m_data = q[pop_idx][0]; m_words = 1; m_stall = 0;
      end
    end else if (ack_v) begin
      m_stall = 0;
      if (m_words < MB && q[m_gid].size() > 0) begin
        pop_idx = m_gid;
        m_data = q[m_gid][0];
        m_words++;
      end else begin
        m_busy = 0; m_req = 0; m_last = m_gid;
      end
    end else begin
`ifdef YAS_ARB_WATCHDOG_EN
      m_stall++;
      if (m_stall == WD) begin
        m_busy = 0; m_req = 0; m_wderr = 1; m_last = m_gid; m_stall = 0;
      end
`endif
    end
    if (pop_idx >= 0) ep[pop_idx] = 1'b1;
    check("pop", 32'(fifo_pop), 32'(ep));
    @(posedge clk);
    #1;
    if (pop_idx >= 0) void'(q[pop_idx].pop_front());
    update_fifos();
  endtask

  // Assert reset on a falling edge, release just after a rising edge.
  task automatic apply_reset(input int fill);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    if (fill > 0) for (int i = 0; i < N; i++) push(i, fill);
    #1;
    check("pop_rst", 32'(fifo_pop), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0;
    data_out_ack = 1'b0;
    update_fifos();
    model_reset();
    apply_reset(0);

    // Single port, three words, ack always.
    push(0, 3);
    for (int i = 0; i < 8; i++) step(1'b1);

    // All ports loaded: bursts of MB with rotating grant.
    for (int p = 0; p < N; p++) push(p, 8);
    for (int i = 0; i < 45; i++) step(1'b1);

    // Single word with ack held back for five cycles.
    push(2, 1);
    for (int i = 0; i < 6; i++) step(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1);

    // Short burst ends on empty FIFO, then the next requester.
    push(1, 2);
    push(3, 4);
    for (int i = 0; i < 12; i++) step(1'b1);

    // Long stall: watchdog drop when enabled, indefinite hold otherwise.
    push(0, 1);
    push(1, 1);
    for (int i = 0; i < 40; i++) step(1'b0);
    for (int i = 0; i < 10; i++) step(1'b1);

    // Reset in the middle of a port-2 burst.
    push(2, 8);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(1'b1);
      if (m_busy && m_gid == 2 && m_words == 2) hit = 1;
    end
    check("mid_wait", 32'(hit), 32'd1);
    apply_reset(2);
    for (int i = 0; i < 30; i++) step(1'b1);

    // Randomized traffic and back-pressure.
    for (int i = 0; i < 1500; i++) begin
      if (i % 250 == 100) begin
        for (int j = 0; j < 20; j++) step(1'b0);
      end
      step(($urandom % 100) < 70);
      if (($urandom % 100) < 20) push(int'($urandom % N), 1 + int'($urandom % 3));
    end

    // Drain whatever remains.
    for (int i = 0; i < 200; i++) step(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
